// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: 32-step shift-add multiply, 32-step restoring
// divide, one-cycle register-file write-back.
// Optional macro MDU_FAST_MUL_EN: multiplies use a single-cycle 64-bit
// product instead of the iterative path; divides are unaffected.
module mul_div_unit #(
  parameter int RD0_WB = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;    // negate the magnitude result in DONE
  logic        quick_q;  // result already final at accept; skip stepping
  logic [31:0] b_q;      // multiplicand / divisor magnitude
  logic [31:0] hi_q;     // product high half / partial remainder
  logic [31:0] lo_q;     // multiplier+product low half / dividend+quotient
  logic [4:0]  cnt_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;

  // Request decode: signedness, magnitudes and the early-out cases
  logic        accept, is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic        div0_in, ovf_in, neg_in, fast_in;
  logic [31:0] a_mag, b_mag;

  assign accept    = in_valid & (state_q == S_IDLE) & ~flush;
  assign is_div_in = in_op[2];
  assign a_sgn_in  = is_div_in ? ~in_op[0] : (in_op != 3'b011);
  assign b_sgn_in  = is_div_in ? ~in_op[0] : ~in_op[1];
  assign a_neg_in  = a_sgn_in & in_a[31];
  assign b_neg_in  = b_sgn_in & in_b[31];
  assign a_mag     = a_neg_in ? (~in_a + 32'd1) : in_a;
  assign b_mag     = b_neg_in ? (~in_b + 32'd1) : in_b;
  assign div0_in   = is_div_in & (in_b == 32'd0);
  assign ovf_in    = is_div_in & ~in_op[0] & (in_a == 32'h8000_0000) &
                     (in_b == 32'hFFFF_FFFF);
  // Remainder takes the dividend's sign; quotient/product the xor of both
  assign neg_in    = (is_div_in & in_op[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

`ifdef MDU_FAST_MUL_EN
  logic [63:0] prod_in;
  assign fast_in = ~is_div_in;
  assign prod_in = {32'd0, a_mag} * {32'd0, b_mag};
`else
  assign fast_in = 1'b0;
`endif

  // One iteration of shift-add multiply or restoring divide
  logic [32:0] sum, rs, diff;
  logic [31:0] hi_step, lo_step;
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    rs   = {hi_q, lo_q[31]};
    diff = rs - {1'b0, b_q};
    if (op_q[2]) begin
      if (!diff[32]) begin
        hi_step = diff[31:0];
        lo_step = {lo_q[30:0], 1'b1};
      end else begin
        hi_step = rs[31:0];
        lo_step = {lo_q[30:0], 1'b0};
      end
    end else begin
      hi_step = sum[32:1];
      lo_step = {sum[0], lo_q[31:1]};
    end
  end

  // Sign correction and result selection, evaluated while in DONE
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, result;
  always_comb begin
    prod_s = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
    quo_s  = neg_q ? (~lo_q + 32'd1) : lo_q;
    rem_s  = neg_q ? (~hi_q + 32'd1) : hi_q;
    case (op_q)
      3'b000:         result = prod_s[31:0];
      3'b001, 3'b010,
      3'b011:         result = prod_s[63:32];
      3'b100, 3'b101: result = quo_s;
      default:        result = rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_BUSY;
      S_BUSY: begin
        if (flush)                          state_d = S_IDLE;
        else if (quick_q || cnt_q == 5'd0)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: write strobe only in DONE, address/data hold between results
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    wb_we    = 1'b0;
    wb_addr  = wb_addr_q;
    wb_data  = wb_data_q;
    if (state_q == S_DONE) begin
      wb_we   = (RD0_WB != 0) || (rd_q != 5'd0);
      wb_addr = rd_q;
      wb_data = result;
    end
  end

  // Operand latch, iteration datapath and write-back hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      neg_q     <= 1'b0;
      quick_q   <= 1'b0;
      b_q       <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      cnt_q     <= 5'd0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else if (accept) begin
      op_q    <= in_op;
      rd_q    <= in_rd;
      b_q     <= b_mag;
      cnt_q   <= 5'd31;
      quick_q <= div0_in | ovf_in | fast_in;
      neg_q   <= neg_in;
      hi_q    <= 32'd0;
      lo_q    <= a_mag;
      if (div0_in) begin
        hi_q  <= in_a;
        lo_q  <= 32'hFFFF_FFFF;
        neg_q <= 1'b0;
      end else if (ovf_in) begin
        hi_q  <= 32'd0;
        lo_q  <= 32'h8000_0000;
        neg_q <= 1'b0;
      end
`ifdef MDU_FAST_MUL_EN
      else if (fast_in) begin
        {hi_q, lo_q} <= prod_in;
      end
`endif
    end else if (state_q == S_BUSY && !flush) begin
      cnt_q <= cnt_q - 5'd1;
      if (!quick_q) begin
        hi_q <= hi_step;
        lo_q <= lo_step;
      end
    end else if (state_q == S_DONE) begin
      wb_addr_q <= rd_q;
      wb_data_q <= result;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected write-backs (address, data,
// completion edge) are queued at issue and checked when wb_we appears.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 32;
`endif
  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
                         OP_MULHU = 3'd3, OP_DIV = 3'd4, OP_DIVU = 3'd5,
                         OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk, rst_n, in_valid, in_ready, flush, wb_we, busy;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, wb_data;
  logic [4:0]  in_rd, wb_addr;

  mul_div_unit #(.RD0_WB(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model for randomized operations
  function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    case (op)
      OP_MUL:    begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[31:0]; end
      OP_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      OP_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb_);
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb_);
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return ML;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  // Drive one request from a negedge with in_ready high; n = accept edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input bit push, output int n);
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1;
    n = cyc + 1;
    if (push) sb.push_back('{addr: rd, data: exp, due: n + lat});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n;
    issue(op, a, b, rd, exp, lat, 1'b1, n);
    wait_ready();
  endtask

  // Write-back monitor
  always @(negedge clk) begin
    if (rst_n && wb_we) begin
      if (sb.size() == 0) chk("spurious_we", 32'd1, 32'd0);
      else begin
        me = sb.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(me.addr));
        chk("wb_data", wb_data, me.data);
        chk("wb_edge", 32'(cyc), 32'(me.due));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    in_op = 3'd0; in_a = 32'd0; in_b = 32'd0; in_rd = 5'd0;
    #1;
    chk("rst_ready",   32'(in_ready), 32'd1);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_we",      32'(wb_we),    32'd0);
    chk("rst_addr",    32'(wb_addr),  32'd0);
    chk("rst_data",    wb_data,       32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiplies
    run(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, ML);
    run(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, ML);
    run(OP_MULH,   32'h8000_0000,  32'd2,         5'd7, 32'hFFFF_FFFF, ML);
    run(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8, 32'hFFFF_FFFF, ML);
    run(OP_MULHSU, 32'd2,          32'hFFFF_FFFF, 5'd9, 32'h0000_0001, ML);

    // Signed divide, with stray in_valid while busy that must be ignored
    issue(OP_DIV, 32'hFFFF_FFEC, 32'd6, 5'd3, 32'hFFFF_FFFD, 32, 1'b1, n);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd1; in_b = 32'd1; in_rd = 5'd9;
    repeat (3) @(negedge clk);
    chk("busy_ignores_valid", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_ready();
    run(OP_REM,  32'hFFFF_FFEC, 32'd6, 5'd3, 32'hFFFF_FFFE, 32);
    run(OP_DIVU, 32'd100,       32'd7, 5'd4, 32'd14,        32);
    run(OP_REMU, 32'd100,       32'd7, 5'd4, 32'd2,         32);

    // Early-out cases
    run(OP_DIVU, 32'd9,         32'd0,         5'd10, 32'hFFFF_FFFF, 1);
    run(OP_REM,  32'd9,         32'd0,         5'd10, 32'd9,         1);
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1);
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);

    // Randomized operations against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run(rop, ra, rb, 5'($urandom_range(1, 31)), ref_f(rop, ra, rb), lat_f(rop, ra, rb));
    end

    // Flush mid-divide at edge N+10, then accept a new request at N+11
    issue(OP_DIV, 32'd1000, 32'd3, 5'd13, 32'd0, 32, 1'b0, n);
    while (cyc < n + 9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_busy",  32'(busy),     32'd0);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 32, 1'b1, n2);
    chk("flush_accept_edge", 32'(n2), 32'(n + 11));
    wait_ready();

    // Flush in IDLE blocks acceptance
    in_op = OP_DIV; in_a = 32'd5; in_b = 32'd1; in_rd = 5'd15;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_flush_no_accept", 32'(busy), 32'd0);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    // rd = 0: no write, busy falls at N+33
    issue(OP_DIV, 32'hFFFF_FFEC, 32'd6, 5'd0, 32'd0, 32, 1'b0, n);
    while (cyc < n + 32) @(negedge clk);
    chk("rd0_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("rd0_busy_fall", 32'(busy), 32'd0);
    @(negedge clk);

    // Reset mid-busy: outputs return to reset values at once, no later write
    issue(OP_DIV, 32'd1000, 32'd3, 5'd16, 32'd0, 32, 1'b0, n);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_we",    32'(wb_we),    32'd0);
    chk("mid_rst_addr",  32'(wb_addr),  32'd0);
    chk("mid_rst_data",  wb_data,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
